// File: rtl/lj_force_pipe_pkg.sv
// lj_force_pipe_pkg: Q-format constants, saturating arithmetic and the coefficient entry type for the LJ pipe
package lj_force_pipe_pkg;
  localparam int LJ_W = 32;
  localparam int LJ_FRAC = 16;
  localparam logic [LJ_W-1:0] QMAX = {1'b0, {(LJ_W-1){1'b1}}};
  localparam logic [LJ_W-1:0] QMIN = {1'b1, {(LJ_W-1){1'b0}}};
  localparam logic [LJ_W-1:0] ONE = LJ_W'(1) << LJ_FRAC;

  typedef struct packed {
    logic [LJ_W-1:0] sigma_sq;
    logic [LJ_W-1:0] eps24;
  } coef_t;

  typedef struct packed {
    logic            sat;
    logic [LJ_W-1:0] v;
  } sval_t;

  // Full-width signed product rescaled by frac bits, clamped to the signed W-bit range.
  function automatic sval_t sat_mul(input logic [LJ_W-1:0] a, input logic [LJ_W-1:0] b, input int frac);
    logic signed [2*LJ_W-1:0] sa;
    logic signed [2*LJ_W-1:0] sb;
    logic signed [2*LJ_W-1:0] p;
    logic ovf;
    sa = (2*LJ_W)'($signed(a));
    sb = (2*LJ_W)'($signed(b));
    p = (sa * sb) >>> frac;
    ovf = !(&p[2*LJ_W-1:LJ_W-1] || ~|p[2*LJ_W-1:LJ_W-1]);
    return '{sat: ovf, v: ovf ? (p[2*LJ_W-1] ? QMIN : QMAX) : p[LJ_W-1:0]};
  endfunction

  function automatic sval_t sat_add(input logic [LJ_W-1:0] a, input logic [LJ_W-1:0] b, input logic sub);
    logic signed [LJ_W:0] s;
    logic ovf;
    s = sub ? (LJ_W+1)'($signed(a)) - (LJ_W+1)'($signed(b))
            : (LJ_W+1)'($signed(a)) + (LJ_W+1)'($signed(b));
    ovf = s[LJ_W] ^ s[LJ_W-1];
    return '{sat: ovf, v: ovf ? (s[LJ_W] ? QMIN : QMAX) : s[LJ_W-1:0]};
  endfunction
endpackage

// File: rtl/lj_coef_table.sv
// lj_coef_table: per-species-pair {sigma^2, 24*eps} register file, one write port, one combinational read port
module lj_coef_table
  import lj_force_pipe_pkg::*;
#(
  parameter int NTYPES = 4,
  parameter int TYPE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [2*TYPE_W-1:0] waddr_i,
  input  coef_t             wdata_i,
  input  logic [2*TYPE_W-1:0] raddr_i,
  output coef_t             rdata_o
);
  coef_t mem_q [NTYPES*NTYPES];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NTYPES*NTYPES; i++) mem_q[i] <= '0;
    else if (we_i)
      mem_q[waddr_i] <= wdata_i;

  // Reads see pre-edge contents, so a pair accepted alongside a write gets the old entry.
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lj_force_pipe.sv
// lj_force_pipe: 7-stage multi-species Lennard-Jones F/r pipeline with valid/ready, cutoff and saturation
module lj_force_pipe
  import lj_force_pipe_pkg::*;
#(
  parameter int W      = LJ_W,
  parameter int FRAC   = LJ_FRAC,
  parameter int NTYPES = 4,
  parameter int TYPE_W = 2,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [TYPE_W-1:0]   type_i,
  input  logic [TYPE_W-1:0]   type_j,
  input  logic [W-1:0]        r2_inv,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [W-1:0]        rc2_inv,
  input  logic                cfg_we,
  input  logic [2*TYPE_W-1:0] cfg_addr,
  input  logic [W-1:0]        cfg_sigma_sq,
  input  logic [W-1:0]        cfg_eps24,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        f_lj,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_sat
);
  localparam int NS = 7;

  coef_t coef_rd, cfg_coef;
  logic en;
  logic [NS-1:0] v_q, sat_q, sat_d;
  logic [5:0] cut_q;
  logic [TAG_W-1:0] tag_q [NS];
  logic [W-1:0] eps_q [5];
  logic [W-1:0] r2_q [6];
  logic [W-1:0] sr2_q, sr4_q, sr2b_q, sr6_q, sr12_q, sr6b_q, term_q, fe_q, f_q;
  sval_t m1, m2, m3, m4, d5, m5, m6, m7;

  assign cfg_coef = '{sigma_sq: cfg_sigma_sq, eps24: cfg_eps24};

  lj_coef_table #(.NTYPES(NTYPES), .TYPE_W(TYPE_W)) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (cfg_we),
    .waddr_i(cfg_addr),
    .wdata_i(cfg_coef),
    .raddr_i({type_i, type_j}),
    .rdata_o(coef_rd)
  );

  // One global enable: the whole pipe holds whenever the output slot is full and not taken.
  assign en        = !v_q[NS-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[NS-1];
  assign f_lj      = f_q;
  assign out_tag   = tag_q[NS-1];
  assign out_sat   = sat_q[NS-1];

  always_comb begin
    m1 = sat_mul(coef_rd.sigma_sq, r2_inv, FRAC);
    m2 = sat_mul(sr2_q, sr2_q, FRAC);
    m3 = sat_mul(sr4_q, sr2b_q, FRAC);
    m4 = sat_mul(sr6_q, sr6_q, FRAC);
    d5 = sat_add(sr12_q, sr12_q, 1'b0);
    m5 = sat_add(d5.v, sr6b_q, 1'b1);
    m6 = sat_mul(term_q, eps_q[4], FRAC);
    m7 = sat_mul(fe_q, r2_q[5], FRAC);
    sat_d = {!cut_q[5] && (sat_q[5] || m7.sat), sat_q[4] | m6.sat, sat_q[3] | d5.sat | m5.sat,
             sat_q[2] | m4.sat, sat_q[1] | m3.sat, sat_q[0] | m2.sat, m1.sat};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q    <= '0;
      sat_q  <= '0;
      cut_q  <= '0;
      sr2_q  <= '0;
      sr4_q  <= '0;
      sr2b_q <= '0;
      sr6_q  <= '0;
      sr12_q <= '0;
      sr6b_q <= '0;
      term_q <= '0;
      fe_q   <= '0;
      f_q    <= '0;
      for (int k = 0; k < NS; k++) tag_q[k] <= '0;
      for (int k = 0; k < 5; k++) eps_q[k] <= '0;
      for (int k = 0; k < 6; k++) r2_q[k] <= '0;
    end else if (en) begin
      v_q      <= {v_q[NS-2:0], in_valid};
      sat_q    <= sat_d;
      cut_q    <= {cut_q[4:0], $signed(r2_inv) < $signed(rc2_inv)};
      tag_q[0] <= in_tag;
      eps_q[0] <= coef_rd.eps24;
      r2_q[0]  <= r2_inv;
      for (int k = 1; k < NS; k++) tag_q[k] <= tag_q[k-1];
      for (int k = 1; k < 5; k++) eps_q[k] <= eps_q[k-1];
      for (int k = 1; k < 6; k++) r2_q[k] <= r2_q[k-1];
      sr2_q  <= m1.v;
      sr4_q  <= m2.v;
      sr2b_q <= sr2_q;
      sr6_q  <= m3.v;
      sr12_q <= m4.v;
      sr6b_q <= sr6_q;
      term_q <= m5.v;
      fe_q   <= m6.v;
      f_q    <= cut_q[5] ? '0 : m7.v;
    end
endmodule

// File: tb/tb_lj_force_pipe.sv
// tb_lj_force_pipe: vector table, random stream against a formula-level model, table-write and reset corner cases
module tb_lj_force_pipe;
  import lj_force_pipe_pkg::*;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, cfg_we = 0;
  logic in_ready, out_valid, out_sat;
  logic [1:0] type_i = 0, type_j = 0;
  logic [31:0] r2_inv = 0, rc2_inv = 0, cfg_sigma_sq = 0, cfg_eps24 = 0, f_lj;
  logic [7:0] in_tag = 0, out_tag;
  logic [3:0] cfg_addr = 0;

  int checks = 0, errors = 0;
  bit rand_rdy = 0;
  bit msat;

  typedef struct {
    logic [7:0]  tag;
    logic        sat;
    logic [31:0] f;
  } exp_t;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] sig, eps, r2, rc2;
    logic [7:0]  tag;
    logic [31:0] f;
    logic        sat;
  } vec_t;

  exp_t exp_q[$];
  logic [31:0] msig [16];
  logic [31:0] meps [16];
  vec_t vt [8];

  always #5 clk = ~clk;

  lj_force_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .type_i(type_i), .type_j(type_j), .r2_inv(r2_inv), .in_tag(in_tag), .rc2_inv(rc2_inv),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sigma_sq(cfg_sigma_sq), .cfg_eps24(cfg_eps24),
    .out_valid(out_valid), .out_ready(out_ready), .f_lj(f_lj), .out_tag(out_tag), .out_sat(out_sat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic longint qs(input longint x);
    if (x > 64'sh7FFFFFFF) begin msat = 1; return 64'sh7FFFFFFF; end
    if (x < -64'sh80000000) begin msat = 1; return -64'sh80000000; end
    return x;
  endfunction

  function automatic longint qm(input longint a, input longint b);
    return qs((a * b) >>> 16);
  endfunction

  // F/r = eps24*(2(s/r)^12-(s/r)^6)*r2_inv evaluated in wide integers, each step clamped to Q16.16.
  function automatic exp_t model(input logic [31:0] sig, eps, r2, rc2, input logic [7:0] tag);
    longint s2, s4, s6, s12, t, f;
    msat = 0;
    s2  = qm(longint'($signed(sig)), longint'($signed(r2)));
    s4  = qm(s2, s2);
    s6  = qm(s4, s2);
    s12 = qm(s6, s6);
    t   = qs(qs(2 * s12) - s6);
    f   = qm(qm(t, longint'($signed(eps))), longint'($signed(r2)));
    if ($signed(r2) < $signed(rc2)) return '{tag, 1'b0, 32'h0};
    return '{tag, msat, f[31:0]};
  endfunction

  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, !(out_valid && !out_ready)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual tag=%h f=%h required=no result", out_tag, f_lj);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result{tag,sat,f}", {23'b0, out_tag, out_sat, f_lj}, {23'b0, e.tag, e.sat, e.f});
        end
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] s, input logic [31:0] e);
    cfg_we = 1; cfg_addr = a; cfg_sigma_sq = s; cfg_eps24 = e;
    @(posedge clk);
    msig[a] = s; meps[a] = e;
    #1 cfg_we = 0;
  endtask

  task automatic send(input logic [3:0] a, input logic [31:0] r2, input logic [31:0] rc2, input logic [7:0] tag,
                      input bit fixed, input logic [31:0] ef, input logic es);
    bit rdy;
    int n;
    exp_t e;
    {type_i, type_j} = a; r2_inv = r2; rc2_inv = rc2; in_tag = tag; in_valid = 1;
    n = 0;
    while (1) begin
      @(negedge clk);
      rdy = in_ready;
      if (fixed) e = '{tag, es, ef};
      else e = model(msig[a], meps[a], r2, rc2, tag);
      @(posedge clk);
      if (rdy) exp_q.push_back(e);
      if (cfg_we) begin msig[cfg_addr] = cfg_sigma_sq; meps[cfg_addr] = cfg_eps24; end
      #1 cfg_we = 0;
      if (rdy) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual in_ready=0 required=1 tag=%h", tag);
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin msig[i] = 0; meps[i] = 0; end
    vt[0] = '{4'd0,  ONE,        ONE,          ONE,        32'h0,    8'h01, 32'h00010000, 1'b0};
    vt[1] = '{4'd0,  ONE,        ONE,          32'h8000,   32'h0,    8'h02, 32'hFFFFF400, 1'b0};
    vt[2] = '{4'd5,  32'h40000,  ONE,          32'h40000,  32'h0,    8'h03, 32'h7FFFFFFF, 1'b1};
    vt[3] = '{4'd15, ONE,        ONE,          32'h2000,   32'h4000, 8'h5A, 32'h0,        1'b0};
    vt[4] = '{4'd3,  ONE,        ONE,          32'h20000,  32'h0,    8'h05, 32'h00F00000, 1'b0};
    vt[5] = '{4'd9,  ONE,        32'h20000,    ONE,        32'h0,    8'h06, 32'h00020000, 1'b0};
    vt[6] = '{4'd0,  ONE,        ONE,          32'h8000,   32'h8000, 8'h07, 32'hFFFFF400, 1'b0};
    vt[7] = '{4'd12, ONE,        32'h80000000, 32'h20000,  32'h0,    8'h08, 32'h80000000, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_f_lj", {32'b0, f_lj}, 64'd0);
    chk("reset_out_tag", {56'b0, out_tag}, 64'd0);
    chk("reset_out_sat", {63'b0, out_sat}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      cfg_write(vt[i].addr, vt[i].sig, vt[i].eps);
      send(vt[i].addr, vt[i].r2, vt[i].rc2, vt[i].tag, 1'b1, vt[i].f, vt[i].sat);
    end
    drain();

    for (int a = 0; a < 16; a++)
      cfg_write(4'(a), $urandom_range(32'h4000, 32'h18000), $urandom_range(0, 32'h40000) - 32'h20000);
    rand_rdy = 1;
    for (int t = 0; t < 20; t++) begin
      send(4'($urandom_range(0, 15)), $urandom_range(32'h4000, 32'h28000), 32'h6000, 8'(t), 1'b0, 32'h0, 1'b0);
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end
    drain();
    rand_rdy = 0;
    @(posedge clk);
    #1;

    cfg_write(4'd6, ONE, ONE);
    cfg_we = 1; cfg_addr = 4'd6; cfg_sigma_sq = 32'h8000; cfg_eps24 = 32'h20000;
    send(4'd6, ONE, 32'h0, 8'hA0, 1'b1, 32'h00010000, 1'b0);
    send(4'd6, ONE, 32'h0, 8'hA1, 1'b1, 32'hFFFFD000, 1'b0);
    drain();

    for (int k = 0; k < 9; k++) send(4'(k + 4), 32'h10000 + 32'(k) * 32'h1000, 32'h0, 8'hB0 + 8'(k), 1'b0, 32'h0, 1'b0);
    rst_n = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin msig[i] = 0; meps[i] = 0; end
    #1;
    chk("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midreset_f_lj", {32'b0, f_lj}, 64'd0);
    chk("midreset_out_tag", {56'b0, out_tag}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (12) @(posedge clk);
    #1;
    send(4'd6, ONE, 32'h0, 8'hC0, 1'b1, 32'h0, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
